// File: rtl/timebase_pkg.sv
// Shared defaults and timer state encoding for the microsecond timebase.
package timebase_pkg;

    localparam int unsigned US_PER_MS_DEF = 1000;
    localparam int unsigned MS_PER_S_DEF  = 1000;
    localparam int unsigned GAP_MAX_DEF   = 127;
    localparam int unsigned TMR_W_DEF     = 16;

    typedef enum logic {
        TMR_IDLE = 1'b0,
        TMR_RUN  = 1'b1
    } tmr_state_e;

endpackage : timebase_pkg

// File: rtl/us_timebase_if.sv
// Control/status bundle of us_timebase.
//   master: drives pluse_us, tmr_load, tmr_val, tmr_periodic, tmr_stop, lost_clr
//   slave : drives us_cnt, pluse_ms, pluse_s, tmr_busy, tmr_expire, us_lost
interface us_timebase_if
    import timebase_pkg::*;
#(
    parameter int unsigned TMR_W = TMR_W_DEF
) ();

    logic             pluse_us;
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_periodic;
    logic             tmr_stop;
    logic             lost_clr;

    logic [31:0]      us_cnt;
    logic             pluse_ms;
    logic             pluse_s;
    logic             tmr_busy;
    logic             tmr_expire;
    logic             us_lost;

    modport master (
        output pluse_us, tmr_load, tmr_val, tmr_periodic, tmr_stop, lost_clr,
        input  us_cnt, pluse_ms, pluse_s, tmr_busy, tmr_expire, us_lost
    );

    modport slave (
        input  pluse_us, tmr_load, tmr_val, tmr_periodic, tmr_stop, lost_clr,
        output us_cnt, pluse_ms, pluse_s, tmr_busy, tmr_expire, us_lost
    );

endinterface : us_timebase_if

// File: rtl/strobe_div.sv
// Mod-N counter advanced by i_en; o_wrap_c flags the enabled cycle that wraps
// N-1 -> 0 so a following stage can chain on it in the same cycle.
//   clk_sys, rst_n : clock, async active-low reset
//   i_en           : count enable
//   o_wrap_c       : combinational wrap strobe
module strobe_div
    import timebase_pkg::*;
#(
    parameter int unsigned N = US_PER_MS_DEF
) (
    input  logic clk_sys,
    input  logic rst_n,
    input  logic i_en,
    output logic o_wrap_c
);

    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [CW-1:0] r_cnt;

    assign o_wrap_c = i_en && (r_cnt == LAST);

    // Division counter
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (o_wrap_c) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule : strobe_div

// File: rtl/us_timebase.sv
// Microsecond timebase: free-running us count, ms/s strobes, one-shot or
// periodic countdown timer, and a sticky alarm for a missing pluse_us.
//   clk_sys, rst_n : clock, async active-low reset
//   bus (slave)    : pluse_us/timer/alarm controls in; count, strobes, status out
module us_timebase
    import timebase_pkg::*;
#(
    parameter int unsigned US_PER_MS = US_PER_MS_DEF,
    parameter int unsigned MS_PER_S  = MS_PER_S_DEF,
    parameter int unsigned TMR_W     = TMR_W_DEF,
    parameter int unsigned GAP_MAX   = GAP_MAX_DEF
) (
    input  logic          clk_sys,
    input  logic          rst_n,
    us_timebase_if.slave  bus
);

    localparam int unsigned GW = (GAP_MAX > 0) ? $clog2(GAP_MAX + 1) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_MAX);

    tmr_state_e       r_state;
    tmr_state_e       w_state_nxt;
    logic [TMR_W-1:0] r_remain;
    logic [TMR_W-1:0] w_remain_nxt;
    logic [TMR_W-1:0] r_reload;
    logic [TMR_W-1:0] w_reload_nxt;
    logic             r_periodic;
    logic             w_periodic_nxt;
    logic             r_expire;
    logic             w_expire_nxt;
    logic             r_busy;

    logic [31:0]      r_us_cnt;
    logic             r_pluse_ms;
    logic             r_pluse_s;
    logic [GW-1:0]    r_gap;
    logic             r_lost;

    logic             w_ms_wrap;
    logic             w_s_wrap;

    // ms stage counts pluse_us; s stage chains on the ms wrap in the same cycle
    strobe_div #(.N(US_PER_MS)) u_ms_div (
        .clk_sys  (clk_sys),
        .rst_n    (rst_n),
        .i_en     (bus.pluse_us),
        .o_wrap_c (w_ms_wrap)
    );

    strobe_div #(.N(MS_PER_S)) u_s_div (
        .clk_sys  (clk_sys),
        .rst_n    (rst_n),
        .i_en     (w_ms_wrap),
        .o_wrap_c (w_s_wrap)
    );

    // Timer next-state: load > stop > countdown; a zero-length load is a no-op
    always_comb begin
        w_state_nxt    = r_state;
        w_remain_nxt   = r_remain;
        w_reload_nxt   = r_reload;
        w_periodic_nxt = r_periodic;
        w_expire_nxt   = 1'b0;

        if (bus.tmr_load) begin
            if (bus.tmr_val != '0) begin
                w_state_nxt    = TMR_RUN;
                w_remain_nxt   = bus.tmr_val;
                w_reload_nxt   = bus.tmr_val;
                w_periodic_nxt = bus.tmr_periodic;
            end
        end else if (bus.tmr_stop) begin
            w_state_nxt = TMR_IDLE;
        end else if ((r_state == TMR_RUN) && bus.pluse_us) begin
            if (r_remain > TMR_W'(1)) begin
                w_remain_nxt = r_remain - TMR_W'(1);
            end else begin
                w_expire_nxt = 1'b1;
                if (r_periodic) begin
                    w_remain_nxt = r_reload;
                end else begin
                    w_state_nxt  = TMR_IDLE;
                    w_remain_nxt = '0;
                end
            end
        end
    end

    // Timer state register
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= TMR_IDLE;
            r_remain   <= '0;
            r_reload   <= '0;
            r_periodic <= 1'b0;
            r_expire   <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_remain   <= w_remain_nxt;
            r_reload   <= w_reload_nxt;
            r_periodic <= w_periodic_nxt;
            r_expire   <= w_expire_nxt;
            r_busy     <= (w_state_nxt == TMR_RUN);
        end
    end

    // us count, strobes and gap watchdog; a set of us_lost beats a clear
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_us_cnt   <= '0;
            r_pluse_ms <= 1'b0;
            r_pluse_s  <= 1'b0;
            r_gap      <= '0;
            r_lost     <= 1'b0;
        end else begin
            r_pluse_ms <= w_ms_wrap;
            r_pluse_s  <= w_s_wrap;

            if (bus.pluse_us) begin
                r_us_cnt <= r_us_cnt + 32'd1;
            end

            if (bus.pluse_us) begin
                r_gap <= '0;
            end else if (r_gap != GAP_LAST) begin
                r_gap <= r_gap + GW'(1);
            end

            if (r_gap == GAP_LAST) begin
                r_lost <= 1'b1;
            end else if (bus.lost_clr) begin
                r_lost <= 1'b0;
            end
        end
    end

    assign bus.us_cnt     = r_us_cnt;
    assign bus.pluse_ms   = r_pluse_ms;
    assign bus.pluse_s    = r_pluse_s;
    assign bus.tmr_busy   = r_busy;
    assign bus.tmr_expire = r_expire;
    assign bus.us_lost    = r_lost;

endmodule : us_timebase

// File: doc/us_timebase.md
# us_timebase

Microsecond timebase consumer sitting directly downstream of the 1 µs strobe `pluse_us` produced in the `clk_sys` domain. It turns the strobe into a free-running microsecond count, millisecond and second strobes, and a loadable one-shot/periodic countdown timer for protocol timeouts. It also watches the strobe itself and raises a sticky alarm if `pluse_us` stops arriving. Single clock domain, `clk_sys` (100 MHz).

## Interface
Parameters:
- `US_PER_MS`, 1000: `pluse_us` strobes per millisecond.
- `MS_PER_S`, 1000: millisecond strobes per second.
- `TMR_W`, 16: countdown timer width in µs.
- `GAP_MAX`, 127: `clk_sys` cycles without `pluse_us` before the alarm fires. The nominal gap is 100.

Ports:
- `clk_sys`  in  1  system clock; every flop in the block uses it.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pluse_us`  in  1  one-cycle strobe, nominally every 100 `clk_sys` cycles.
- `tmr_load`  in  1  one-cycle request to (re)load the countdown timer.
- `tmr_val`  in  `TMR_W`  countdown length in µs; sampled when `tmr_load`=1.
- `tmr_periodic`  in  1  sampled with `tmr_load`; 1 = auto-reload on expiry.
- `tmr_stop`  in  1  one-cycle request to abort the timer.
- `lost_clr`  in  1  clears `us_lost`.
- `us_cnt`  out  32  free-running µs count; wraps 0xFFFFFFFF to 0.
- `pluse_ms`  out  1  one-cycle strobe every `US_PER_MS` µs.
- `pluse_s`  out  1  one-cycle strobe every `MS_PER_S` ms.
- `tmr_busy`  out  1  timer is running.
- `tmr_expire`  out  1  one-cycle strobe when the countdown reaches its end.
- `us_lost`  out  1  sticky alarm: `pluse_us` is missing.

## Operation
- Reset: all outputs are 0. Divider counts, gap counter and timer remaining are 0. The FSM is in IDLE.
- `us_cnt` increments by 1 on every `pluse_us`.
- ms divider:
  - `ms_div` counts 0..`US_PER_MS`-1 on `pluse_us`.
  - On `pluse_us` with `ms_div`=`US_PER_MS`-1: `ms_div` goes to 0 and `pluse_ms` pulses.
- s divider: same rule clocked by the ms wrap event; `pluse_s` pulses in the same cycle as the `pluse_ms` that wraps it.
- Timer FSM, states IDLE and RUN. Priority in any state: `tmr_load` > `tmr_stop` > countdown.
  - `tmr_load` with `tmr_val`≠0: remaining and reload are set to `tmr_val`, `periodic` is latched, the FSM goes to RUN. This works from RUN too (restart).
  - `tmr_load` with `tmr_val`=0: ignored; state is unchanged.
  - `tmr_stop`: the FSM goes to IDLE with no expire. Ignored in IDLE.
  - In RUN, on `pluse_us` with remaining>1: remaining decrements.
  - In RUN, on `pluse_us` with remaining=1: `tmr_expire` pulses. If `periodic`, remaining is set to reload and the FSM stays in RUN; otherwise it goes to IDLE.
  - A `pluse_us` in the same cycle as `tmr_load` is not counted.
- Gap watchdog:
  - The gap counter clears on `pluse_us`; otherwise it increments, saturating at `GAP_MAX`.
  - Reaching `GAP_MAX` sets `us_lost`.
  - `lost_clr` clears `us_lost`; if set and clear occur in the same cycle, set wins.
  - After reset, the first `pluse_us` must arrive within `GAP_MAX` cycles or `us_lost` sets.
- Mid-operation `rst_n` assertion returns everything to reset values immediately (asynchronous). No expire or strobe is emitted.

## Timing
- Every output is registered. A `pluse_us` sampled high at edge N produces the following at edge N+1:
  - `us_cnt` update;
  - `pluse_ms` / `pluse_s`;
  - `tmr_expire`.
- `tmr_load` at edge N: `tmr_busy`=1 from N+1. The first decrement happens on the next `pluse_us` after N.
- One-shot with `tmr_val`=V: `tmr_expire` occurs 1 cycle after the V-th `pluse_us` following the load. `tmr_busy` falls in the same cycle `tmr_expire` rises.
- Periodic: `tmr_expire` repeats every V `pluse_us`, and `tmr_busy` stays 1.
- `tmr_stop` at edge N: `tmr_busy`=0 from N+1.
- `us_lost` rises 1 cycle after the gap counter hits `GAP_MAX`.
- `lost_clr` at edge N: `us_lost`=0 from N+1.

## Structure
- Shared package `timebase_pkg` holds:
  - `US_PER_MS`, `MS_PER_S` and `GAP_MAX` defaults;
  - the timer state encoding (IDLE=0, RUN=1).
- Sub-module `strobe_div` (parameter N) is a mod-N counter with enable in and a one-cycle wrap strobe out. It is instantiated twice: ms stage and s stage.
- Timer FSM, `us_cnt` and the watchdog live in the top level.

## Test plan
- Reset, then `pluse_us` every 100 cycles for 2,000,000 µs (`US_PER_MS`=1000, `MS_PER_S`=1000) -> `us_cnt`=2,000,000; 2000 `pluse_ms`; 2 `pluse_s`, each coincident with a `pluse_ms`; no `us_lost`.
- `tmr_load`, `tmr_val`=5, `tmr_periodic`=0 -> `tmr_expire` 1 cycle after the 5th `pluse_us`; `tmr_busy` 1→0 in the same cycle; no further expires.
- `tmr_val`=3, periodic -> expires after `pluse_us` #3, #6 and #9. `tmr_stop` after #7 -> no expire at #9; `tmr_busy`=0.
- `tmr_load` coincident with `pluse_us`, `tmr_val`=2 -> that pulse is not counted; expire follows the 2nd later pulse. `tmr_load` with `tmr_val`=0 -> no state change.
- Withhold `pluse_us` for 128 cycles -> `us_lost`=1 and stays 1 after pulses resume. `lost_clr` -> 0. `lost_clr` in the same cycle as a set -> stays 1.
- Assert `rst_n` low while the timer is in RUN with remaining=2 -> all outputs are 0 immediately; no `tmr_expire` after release.
